tank_pose_controller: RTL



---
 rtl/tank_pose_controller.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/tank_pose_controller.sv
// tank_pose_controller
// Per-frame pose sequencer for two tanks. A frame tick latches the player
// keys, then each tank in turn rotates, looks up sin/cos from the shared
// synchronous trig ROM and moves in Q10.8 fixed point with screen clamping.
// The finished pose set is committed to the outputs in a single edge, so the
// renderer never sees a half-updated frame.
module tank_pose_controller #(
  parameter int         ANGLE_STEPS = 32,
  parameter int         SPEED       = 2,
  parameter int         TANK_SIZE   = 8,
  parameter int         X1_INIT     = 160,
  parameter int         Y1_INIT     = 240,
  parameter int         X2_INIT     = 480,
  parameter int         Y2_INIT     = 240,
  parameter int         A1_INIT     = 0,
  parameter int         A2_INIT     = 16,
  // Reset trig values must match the ROM entries of A1_INIT / A2_INIT.
  parameter logic [7:0] SIN1_INIT   = 8'h00,
  parameter logic [7:0] COS1_INIT   = 8'h7F,
  parameter logic [7:0] SIN2_INIT   = 8'h00,
  parameter logic [7:0] COS2_INIT   = 8'h81,
  localparam int        AW          = $clog2(ANGLE_STEPS)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          frame_tick,
  input  logic [3:0]    keys1,
  input  logic [3:0]    keys2,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_sin,
  input  logic [7:0]    rom_cos,
  output logic [9:0]    TankX1,
  output logic [9:0]    TankY1,
  output logic [9:0]    TankX2,
  output logic [9:0]    TankY2,
  output logic [7:0]    sin1,
  output logic [7:0]    cos1,
  output logic [7:0]    sin2,
  output logic [7:0]    cos2,
  output logic [AW-1:0] angle1,
  output logic [AW-1:0] angle2,
  output logic          busy,
  output logic          update_done,
  output logic          overrun
);

  typedef enum logic [2:0] {
    IDLE, T1_ANG, T1_WAIT, T1_MOVE, T2_ANG, T2_WAIT, T2_MOVE, COMMIT
  } state_t;

  // Step per frame in Q.8 units is trig * SPEED * 2 (trig is Q1.7).
  localparam logic signed [19:0] SPEED2 = 20'(2 * SPEED);
  // Clamp limits expressed directly in Q10.8 so no shifting is needed.
  localparam logic signed [19:0] X_LO_Q = 20'(TANK_SIZE * 256);
  localparam logic signed [19:0] X_HI_Q = 20'((639 - TANK_SIZE) * 256);
  localparam logic signed [19:0] Y_LO_Q = 20'(TANK_SIZE * 256);
  localparam logic signed [19:0] Y_HI_Q = 20'((479 - TANK_SIZE) * 256);

  state_t     state;
  state_t     state_next;
  logic       accept;
  logic       commit;
  logic [1:0] ang_en;
  logic [1:0] move_en;

  // Clamp a Q10.8 sum so its integer part stays in [lo, hi]; a clamped
  // axis lands exactly on the limit with a zero fraction.
  function automatic logic [17:0] clamp_q(input logic signed [19:0] v,
                                          input logic signed [19:0] lo_q,
                                          input logic signed [19:0] hi_q);
    if (v < lo_q)
      return 18'(lo_q);
    else if (v >= hi_q + 20'sd256)
      return 18'(hi_q);
    else
      return 18'(v);
  endfunction

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Sequencing: next state, per-tank step enables and ROM address select.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    commit     = 1'b0;
    ang_en     = 2'b00;
    move_en    = 2'b00;
    rom_addr   = g_tank[0].work_a;
    case (state)
      IDLE: begin
        if (frame_tick) begin
          accept     = 1'b1;
          state_next = T1_ANG;
        end
      end
      T1_ANG: begin
        ang_en[0]  = 1'b1;
        state_next = T1_WAIT;
      end
      T1_WAIT: state_next = T1_MOVE;
      T1_MOVE: begin
        move_en[0] = 1'b1;
        state_next = T2_ANG;
      end
      T2_ANG: begin
        ang_en[1]  = 1'b1;
        state_next = T2_WAIT;
      end
      T2_WAIT: begin
        rom_addr   = g_tank[1].work_a;
        state_next = T2_MOVE;
      end
      T2_MOVE: begin
        move_en[1] = 1'b1;
        state_next = COMMIT;
      end
      COMMIT: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Completion pulse follows the commit edge; overrun is sticky until reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      update_done <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      update_done <= commit;
      if (frame_tick && busy) overrun <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_tank
    localparam logic [9:0]    X_INIT = 10'(gi == 0 ? X1_INIT : X2_INIT);
    localparam logic [9:0]    Y_INIT = 10'(gi == 0 ? Y1_INIT : Y2_INIT);
    localparam logic [AW-1:0] A_INIT = AW'(gi == 0 ? A1_INIT : A2_INIT);
    localparam logic [7:0]    S_INIT = (gi == 0) ? SIN1_INIT : SIN2_INIT;
    localparam logic [7:0]    C_INIT = (gi == 0) ? COS1_INIT : COS2_INIT;

    logic [3:0]        keys_in;
    logic [3:0]        keys_sh;
    logic              fwd, back, left, right;
    logic [AW-1:0]     work_a;
    logic [17:0]       work_x, work_y;
    logic [7:0]        work_sin, work_cos;
    logic [AW-1:0]     out_a;
    logic [9:0]        out_x, out_y;
    logic [7:0]        out_sin, out_cos;
    logic signed [19:0] sin_ext, cos_ext;
    logic signed [19:0] sin_term, cos_term;
    logic signed [19:0] x_sum, y_sum;

    assign keys_in = (gi == 0) ? keys1 : keys2;
    assign {fwd, back, left, right} = keys_sh;

    // Candidate position for this tank using the trig word arriving this cycle.
    always_comb begin
      sin_ext  = {{12{rom_sin[7]}}, rom_sin};
      cos_ext  = {{12{rom_cos[7]}}, rom_cos};
      sin_term = sin_ext * SPEED2;
      cos_term = cos_ext * SPEED2;
      x_sum    = {2'b00, work_x};
      y_sum    = {2'b00, work_y};
      if (fwd && !back) begin
        x_sum = x_sum + cos_term;
        y_sum = y_sum - sin_term;
      end else if (back && !fwd) begin
        x_sum = x_sum - cos_term;
        y_sum = y_sum + sin_term;
      end
    end

    // Working pose, key shadow and committed outputs for this tank.
    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        keys_sh  <= 4'b0000;
        work_a   <= A_INIT;
        work_x   <= {X_INIT, 8'd0};
        work_y   <= {Y_INIT, 8'd0};
        work_sin <= S_INIT;
        work_cos <= C_INIT;
        out_a    <= A_INIT;
        out_x    <= X_INIT;
        out_y    <= Y_INIT;
        out_sin  <= S_INIT;
        out_cos  <= C_INIT;
      end else begin
        if (accept) keys_sh <= keys_in;
        if (ang_en[gi]) begin
          if (left && !right)      work_a <= work_a + AW'(1);
          else if (right && !left) work_a <= work_a - AW'(1);
        end
        if (move_en[gi]) begin
          work_sin <= rom_sin;
          work_cos <= rom_cos;
          work_x   <= clamp_q(x_sum, X_LO_Q, X_HI_Q);
          work_y   <= clamp_q(y_sum, Y_LO_Q, Y_HI_Q);
        end
        if (commit) begin
          out_a   <= work_a;
          out_x   <= work_x[17:8];
          out_y   <= work_y[17:8];
          out_sin <= work_sin;
          out_cos <= work_cos;
        end
      end
    end
  end

  assign TankX1 = g_tank[0].out_x;
  assign TankY1 = g_tank[0].out_y;
  assign TankX2 = g_tank[1].out_x;
  assign TankY2 = g_tank[1].out_y;
  assign sin1   = g_tank[0].out_sin;
  assign cos1   = g_tank[0].out_cos;
  assign sin2   = g_tank[1].out_sin;
  assign cos2   = g_tank[1].out_cos;
  assign angle1 = g_tank[0].out_a;
  assign angle2 = g_tank[1].out_a;

endmodule
